// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - DVI/HDMI TMDS 8b/10b channel encoder with running disparity
module tmds_encoder #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       i_data,
    input  logic             i_de,
    input  logic             i_c0,
    input  logic             i_c1,
    output logic [9:0]       o_tmds,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Stage 1 state: transition-minimised word plus delayed control.
    logic [8:0] q_m;
    logic       de;
    logic       c0;
    logic       c1;

    logic [3:0] n1_d;
    logic       xnor_mode;
    logic [8:0] q_m_d;

    // Stage 2 state: running disparity after the symbol on o_tmds.
    logic signed [CNT_W-1:0] cnt;

    logic [3:0]              n1_q;
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] n0_s;
    logic signed [CNT_W-1:0] diff;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              tmds_d;
    logic signed [CNT_W-1:0] cnt_d;

    // Pick XOR/XNOR chaining from the input popcount and build q_m.
    always_comb begin
        n1_d = '0;
        for (int i = 0; i < 8; i++) begin
            n1_d = n1_d + {3'b000, i_data[i]};
        end
        xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !i_data[0]);
        q_m_d     = '0;
        q_m_d[0]  = i_data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_d[i] = xnor_mode ? ~(q_m_d[i-1] ^ i_data[i]) : (q_m_d[i-1] ^ i_data[i]);
        end
        q_m_d[8] = ~xnor_mode;
    end

    // Stage 1 register: q_m travels with its de/c0/c1 so symbols never mix.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_m <= '0;
            de  <= 1'b0;
            c0  <= 1'b0;
            c1  <= 1'b0;
        end else begin
            q_m <= q_m_d;
            de  <= i_de;
            c0  <= i_c0;
            c1  <= i_c1;
        end
    end

    // Choose inversion to steer the running disparity back towards zero.
    always_comb begin
        n1_q = '0;
        for (int i = 0; i < 8; i++) begin
            n1_q = n1_q + {3'b000, q_m[i]};
        end
        n1_s    = CNT_W'(n1_q);
        n0_s    = EIGHT - n1_s;
        diff    = n1_s - n0_s;
        cnt_neg = cnt[CNT_W-1];
        cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
        tmds_d  = CTRL_00;
        cnt_d   = '0;
        if (!de) begin
            unique case ({c1, c0})
                2'b00:   tmds_d = CTRL_00;
                2'b01:   tmds_d = CTRL_01;
                2'b10:   tmds_d = CTRL_10;
                default: tmds_d = CTRL_11;
            endcase
            cnt_d = '0;
        end else if ((cnt == '0) || (diff == '0)) begin
            tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_d  = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if ((cnt_pos && (n1_s > n0_s)) || (cnt_neg && (n0_s > n1_s))) begin
            tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_d  = cnt + (q_m[8] ? TWO : '0) - diff;
        end else begin
            tmds_d = {1'b0, q_m[8], q_m[7:0]};
            cnt_d  = cnt + diff - (q_m[8] ? '0 : TWO);
        end
    end

    // Stage 2 register: output symbol and disparity.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_tmds <= CTRL_00;
            cnt    <= '0;
        end else begin
            o_tmds <= tmds_d;
            cnt    <= cnt_d;
        end
    end

    assign o_cnt = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - scoreboard bench for tmds_encoder against a reference model
module tb_tmds_encoder;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic [7:0]       i_data;
    logic             i_de;
    logic             i_c0;
    logic             i_c1;
    logic [9:0]       o_tmds;
    logic [CNT_W-1:0] o_cnt;

    always #5 clk = ~clk;

    tmds_encoder #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_data (i_data),
        .i_de   (i_de),
        .i_c0   (i_c0),
        .i_c1   (i_c1),
        .o_tmds (o_tmds),
        .o_cnt  (o_cnt)
    );

    typedef struct {
        logic [9:0] tmds;
        int         cnt;
        bit         active;
        logic [7:0] data;
        bit         has_fix;
        logic [9:0] fix_tmds;
        int         fix_cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         m_cnt   = 0;
    bit         p_rstn  = 1'b0;
    bit         p_de    = 1'b0;
    bit         p_c0    = 1'b0;
    bit         p_c1    = 1'b0;
    logic [7:0] p_data  = 8'h00;

    bit         fix_pending = 1'b0;
    logic [9:0] fix_t       = '0;
    int         fix_c       = 0;

    function automatic logic [9:0] ctrl_code(input bit c1, input bit c0);
        case ({c1, c0})
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Transaction-level encode: q_m bit i is the parity of d[i:0], flipped on
    // odd bits in XNOR mode; then pick inversion by disparity rules.
    task automatic encode(input logic [7:0] d, output logic [9:0] tm);
        int         ones;
        bit         xn;
        logic [7:0] q;
        logic [7:0] m;
        bit         q8;
        int         disp;
        ones = $countones(d);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            m    = 8'((1 << (i + 1)) - 1);
            q[i] = (^(d & m)) ^ (xn && (i % 2 == 1));
        end
        q8   = !xn;
        disp = 2 * $countones(q) - 8;
        if (m_cnt == 0 || disp == 0) begin
            tm    = {~q8, q8, q8 ? q : ~q};
            m_cnt = m_cnt + (q8 ? disp : -disp);
        end else if ((m_cnt > 0 && disp > 0) || (m_cnt < 0 && disp < 0)) begin
            tm    = {1'b1, q8, ~q};
            m_cnt = m_cnt + 2 * int'(q8) - disp;
        end else begin
            tm    = {1'b0, q8, q};
            m_cnt = m_cnt + disp - 2 * int'(!q8);
        end
    endtask

    task automatic expect_next(input logic [9:0] t, input int c);
        fix_pending = 1'b1;
        fix_t       = t;
        fix_c       = c;
    endtask

    // Drive one cycle and push the expected output for the coming edge.
    task automatic step(input bit r, input bit d_e, input bit c1, input bit c0,
                        input logic [7:0] d);
        exp_t e;
        rstn   = r;
        i_de   = d_e;
        i_c1   = c1;
        i_c0   = c0;
        i_data = d;
        e.active = 1'b0;
        e.data   = p_data;
        if (!r || !p_rstn) begin
            e.tmds = 10'h354;
            m_cnt  = 0;
        end else if (!p_de) begin
            e.tmds = ctrl_code(p_c1, p_c0);
            m_cnt  = 0;
        end else begin
            encode(p_data, e.tmds);
            e.active = 1'b1;
        end
        e.cnt      = m_cnt;
        e.has_fix  = fix_pending;
        e.fix_tmds = fix_t;
        e.fix_cnt  = fix_c;
        fix_pending = 1'b0;
        sbq.push_back(e);
        p_rstn = r;
        p_de   = d_e;
        p_c1   = c1;
        p_c0   = c0;
        p_data = d;
        @(negedge clk);
    endtask

    // Monitor: one expected entry per clock edge, compared on the falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t       e;
            int         act_cnt;
            logic [7:0] q;
            logic [7:0] dec;
            e       = sbq.pop_front();
            act_cnt = int'($signed(o_cnt));
            checks++;
            if (o_tmds !== e.tmds) begin
                errors++;
                $display("FAIL tmds: got %h want %h at %0t", o_tmds, e.tmds, $time);
            end
            checks++;
            if (act_cnt != e.cnt) begin
                errors++;
                $display("FAIL cnt: got %0d want %0d at %0t", act_cnt, e.cnt, $time);
            end
            checks++;
            if (act_cnt > 10 || act_cnt < -10) begin
                errors++;
                $display("FAIL cnt_range: got %0d want within +-10 at %0t", act_cnt, $time);
            end
            if (e.active) begin
                q      = o_tmds[9] ? ~o_tmds[7:0] : o_tmds[7:0];
                dec[0] = q[0];
                for (int i = 1; i < 8; i++) begin
                    dec[i] = o_tmds[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
                checks++;
                if (dec !== e.data) begin
                    errors++;
                    $display("FAIL decode: got %h want %h at %0t", dec, e.data, $time);
                end
            end
            if (e.has_fix) begin
                checks++;
                if (o_tmds !== e.fix_tmds || act_cnt != e.fix_cnt) begin
                    errors++;
                    $display("FAIL directed: got %h/%0d want %h/%0d at %0t",
                             o_tmds, act_cnt, e.fix_tmds, e.fix_cnt, $time);
                end
            end
        end
    end

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            expect_next(10'h354, 0);
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        end
        // Release with {c1,c0}=01; code shows two edges after release
        expect_next(10'h354, 0); step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_next(10'h0AB, 0); step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Control sweep 01,10,11 following the 00 above
        expect_next(10'h354, 0); step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_next(10'h0AB, 0); step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        expect_next(10'h154, 0); step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        // Three 0x00 data symbols from cnt=0
        expect_next(10'h2AB, 0); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_next(10'h100, -8); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_next(10'h3FF, 2); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_next(10'h100, -6); step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // 0xFF from cnt=0, then 0x00, then blanking zeroes cnt, then re-enable
        expect_next(10'h354, 0); step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        expect_next(10'h200, -8); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_next(10'h3FF, 2); step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_next(10'h354, 0); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_next(10'h100, -8); step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        // Randomised traffic with occasional mid-stream reset
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 8'($urandom));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
